// File: rtl/light_game_pkg.sv
// light_game_pkg
// Shared constants and types for the light-cycle game blocks.
//   - Screen geometry (H_ACTIVE, V_ACTIVE) and cell geometry (CELL_LOG2,
//     GRID_W, GRID_H, DEPTH, ADDR_W).
//   - Owner encoding stored in the trail grid (OWN_EMPTY, OWN_P1, OWN_P2).
//   - Player trail colours as packed {R,G,B}.
//   - State encoding of the trail grid controller.
//   - Helpers: pixel-to-cell address and owner-to-colour lookup.
package light_game_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int CELL_LOG2 = 3;
    localparam int GRID_W    = H_ACTIVE >> CELL_LOG2;
    localparam int GRID_H    = V_ACTIVE >> CELL_LOG2;
    localparam int DEPTH     = GRID_W * GRID_H;
    localparam int ADDR_W    = $clog2(DEPTH);

    // Screen limits at the width of the 10-bit coordinate ports.
    localparam logic [9:0] H_LIMIT = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIMIT = 10'(V_ACTIVE);

    localparam logic [1:0] OWN_EMPTY = 2'd0;
    localparam logic [1:0] OWN_P1    = 2'd1;
    localparam logic [1:0] OWN_P2    = 2'd2;

    localparam logic [23:0] COLOUR_NONE = 24'h000000;
    localparam logic [23:0] COLOUR_P1   = 24'hFFFF00;
    localparam logic [23:0] COLOUR_P2   = 24'h00FFFF;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOOKUP,
        ST_CHECK
    } grid_state_t;

    // Row-major cell index. GRID_W is 80, so the multiply by the row is
    // done as (cy*64 + cy*16) to stay a pair of shifts and one adder chain.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [9:0] x,
                                                    input logic [9:0] y);
        logic [ADDR_W-1:0] cx;
        logic [ADDR_W-1:0] cy;
        cx = ADDR_W'(x >> CELL_LOG2);
        cy = ADDR_W'(y >> CELL_LOG2);
        return (cy << 6) + (cy << 4) + cx;
    endfunction

    // The unused owner code 3 renders as empty.
    function automatic logic [23:0] owner_colour(input logic [1:0] owner);
        case (owner)
            OWN_P1:  return COLOUR_P1;
            OWN_P2:  return COLOUR_P2;
            default: return COLOUR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/trail_ram.sv
// trail_ram
// Simple dual-port synchronous RAM holding one 2-bit owner code per cell.
//   clock     in   clock
//   addrA_i   in   pixel port read address
//   rdataA_o  out  pixel port read data, one cycle after the address
//   addrB_i   in   controller port address
//   weB_i     in   controller port write enable
//   wdataB_i  in   controller port write data
//   rdataB_o  out  controller port read data, one cycle latency, write-first
module trail_ram #(
    parameter int DEPTH  = 4800,
    parameter int ADDR_W = 13
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] addrA_i,
    output logic [1:0]        rdataA_o,
    input  logic [ADDR_W-1:0] addrB_i,
    input  logic              weB_i,
    input  logic [1:0]        wdataB_i,
    output logic [1:0]        rdataB_o
);

    logic [1:0] mem [DEPTH];

    // Pixel port: read only, registered output.
    always_ff @(posedge clock) begin
        rdataA_o <= mem[addrA_i];
    end

    // Controller port: a write also returns the written value so the
    // controller never sees stale data for a cell it just claimed.
    always_ff @(posedge clock) begin
        if (weB_i) begin
            mem[addrB_i] <= wdataB_i;
            rdataB_o     <= wdataB_i;
        end else begin
            rdataB_o     <= mem[addrB_i];
        end
    end

endmodule

// File: rtl/light_trail_grid.sv
// light_trail_grid
// Occupancy memory for the light-cycle game. Records each cell a player
// head visits, reports trail and off-screen crashes, and renders trail
// colour for the VGA scan.
//   CLOCK_50          in   system clock
//   reset             in   synchronous, active-high
//   clear_req         in   one-cycle pulse, wipe the grid
//   busy              out  high while the grid is being wiped
//   move_valid        in   move request
//   move_ready        out  high while idle
//   move_player       in   0 = player 1, 1 = player 2
//   move_x, move_y    in   head pixel position
//   move_done         out  one-cycle pulse per accepted move
//   collision         out  crash flag, valid with move_done
//   collision_player  out  player of the most recent crash
//   pix_x, pix_y      in   scan position, colour appears three cycles later
//   pix_r/g/b         out  registered trail colour
module light_trail_grid
    import light_game_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       clear_req,
    output logic       busy,
    input  logic       move_valid,
    output logic       move_ready,
    input  logic       move_player,
    input  logic [9:0] move_x,
    input  logic [9:0] move_y,
    output logic       move_done,
    output logic       collision,
    output logic       collision_player,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic [7:0] pix_r,
    output logic [7:0] pix_g,
    output logic [7:0] pix_b
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    grid_state_t       state_q, state_d;
    logic [ADDR_W-1:0] clrAddr_q, clrAddr_d;
    logic [ADDR_W-1:0] mvAddr_q, mvAddr_d;
    logic              mvPlayer_q, mvPlayer_d;
    logic              mvOob_q, mvOob_d;
    logic              moveDone_q, moveDone_d;
    logic              collision_q, collision_d;
    logic              collPlayer_q, collPlayer_d;

    logic [ADDR_W-1:0] ramAddrB;
    logic              ramWeB;
    logic [1:0]        ramWdataB;
    logic [1:0]        ramRdataB;
    logic [1:0]        ramRdataA;
    logic              crash;

    logic              pixInRange;
    logic [ADDR_W-1:0] pixAddr_q;
    logic              pixInRange_q;
    logic              pixValid_q;
    logic [23:0]       colour_q;

    trail_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_trail_ram (
        .clock    (CLOCK_50),
        .addrA_i  (pixAddr_q),
        .rdataA_o (ramRdataA),
        .addrB_i  (ramAddrB),
        .weB_i    (ramWeB),
        .wdataB_i (ramWdataB),
        .rdataB_o (ramRdataB)
    );

    // Controller registers. Reset lands in CLEAR so the RAM, which has no
    // reset of its own, is wiped before the first move is taken.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            clrAddr_q    <= '0;
            mvAddr_q     <= '0;
            mvPlayer_q   <= 1'b0;
            mvOob_q      <= 1'b0;
            moveDone_q   <= 1'b0;
            collision_q  <= 1'b0;
            collPlayer_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clrAddr_q    <= clrAddr_d;
            mvAddr_q     <= mvAddr_d;
            mvPlayer_q   <= mvPlayer_d;
            mvOob_q      <= mvOob_d;
            moveDone_q   <= moveDone_d;
            collision_q  <= collision_d;
            collPlayer_q <= collPlayer_d;
        end
    end

    // Next-state and RAM port B control. Off-screen moves capture address 0
    // so the lookup never reads outside the array; they never write anyway.
    // A clear request overrides whatever the case statement decided, which
    // abandons an in-flight move with no write and no done pulse.
    always_comb begin
        state_d      = state_q;
        clrAddr_d    = clrAddr_q;
        mvAddr_d     = mvAddr_q;
        mvPlayer_d   = mvPlayer_q;
        mvOob_d      = mvOob_q;
        moveDone_d   = 1'b0;
        collision_d  = 1'b0;
        collPlayer_d = collPlayer_q;
        ramAddrB     = mvAddr_q;
        ramWeB       = 1'b0;
        ramWdataB    = OWN_EMPTY;
        crash        = mvOob_q || (ramRdataB != OWN_EMPTY);

        unique case (state_q)
            ST_CLEAR: begin
                ramAddrB  = clrAddr_q;
                ramWeB    = 1'b1;
                clrAddr_d = clrAddr_q + ADDR_W'(1);
                if (clrAddr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (move_valid) begin
                    mvOob_d    = (move_x >= H_LIMIT) || (move_y >= V_LIMIT);
                    mvAddr_d   = mvOob_d ? '0 : cell_addr(move_x, move_y);
                    mvPlayer_d = move_player;
                    state_d    = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (crash) begin
                    collision_d  = 1'b1;
                    collPlayer_d = mvPlayer_q;
                end else begin
                    ramWeB    = 1'b1;
                    ramWdataB = mvPlayer_q ? OWN_P2 : OWN_P1;
                end
                moveDone_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        if (clear_req) begin
            state_d      = ST_CLEAR;
            clrAddr_d    = '0;
            mvAddr_d     = mvAddr_q;
            mvPlayer_d   = mvPlayer_q;
            mvOob_d      = mvOob_q;
            moveDone_d   = 1'b0;
            collision_d  = 1'b0;
            collPlayer_d = collPlayer_q;
            ramWeB       = 1'b0;
        end
    end

    assign pixInRange = (pix_x < H_LIMIT) && (pix_y < V_LIMIT);

    // Pixel pipeline: address, RAM read, colour. The in-range flag travels
    // alongside the RAM read so off-screen pixels come out black.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pixAddr_q    <= '0;
            pixInRange_q <= 1'b0;
            pixValid_q   <= 1'b0;
            colour_q     <= COLOUR_NONE;
        end else begin
            pixAddr_q    <= pixInRange ? cell_addr(pix_x, pix_y) : '0;
            pixInRange_q <= pixInRange;
            pixValid_q   <= pixInRange_q;
            colour_q     <= pixValid_q ? owner_colour(ramRdataA) : COLOUR_NONE;
        end
    end

    assign busy             = (state_q == ST_CLEAR);
    assign move_ready       = (state_q == ST_IDLE);
    assign move_done        = moveDone_q;
    assign collision        = collision_q;
    assign collision_player = collPlayer_q;
    assign pix_r            = colour_q[23:16];
    assign pix_g            = colour_q[15:8];
    assign pix_b            = colour_q[7:0];

endmodule

// File: tb/tb_light_trail_grid.sv
// tb_light_trail_grid
// Self-checking bench for light_trail_grid. A grid of owner values indexed
// by (y/8)*80 + x/8 stands in for the design's memory.
module tb_light_trail_grid;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       clear_req = 1'b0;
    logic       busy;
    logic       move_valid = 1'b0;
    logic       move_ready;
    logic       move_player = 1'b0;
    logic [9:0] move_x = '0;
    logic [9:0] move_y = '0;
    logic       move_done;
    logic       collision;
    logic       collision_player;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic [7:0] pix_r, pix_g, pix_b;

    int testsRun = 0;
    int testsFailed = 0;

    int grid [4800];
    int lastCrashPlayer = 0;
    int scanX [$];
    int scanY [$];

    light_trail_grid dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .clear_req        (clear_req),
        .busy             (busy),
        .move_valid       (move_valid),
        .move_ready       (move_ready),
        .move_player      (move_player),
        .move_x           (move_x),
        .move_y           (move_y),
        .move_done        (move_done),
        .collision        (collision),
        .collision_player (collision_player),
        .pix_x            (pix_x),
        .pix_y            (pix_y),
        .pix_r            (pix_r),
        .pix_g            (pix_g),
        .pix_b            (pix_b)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #(20 * 200000);
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic int cell_index(int x, int y);
        return (y / 8) * 80 + (x / 8);
    endfunction

    function automatic logic [23:0] model_colour(int x, int y);
        if (x >= 640 || y >= 480) return 24'h000000;
        case (grid[cell_index(x, y)])
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic void model_clear();
        foreach (grid[i]) grid[i] = 0;
    endfunction

    // Returns the expected crash flag and updates the model grid.
    function automatic logic model_move(int player, int x, int y);
        if (x >= 640 || y >= 480 || grid[cell_index(x, y)] != 0) begin
            lastCrashPlayer = player;
            return 1'b1;
        end
        grid[cell_index(x, y)] = player + 1;
        return 1'b0;
    endfunction

    function automatic void add_cell_block(int x0, int y0);
        for (int dy = 0; dy < 8; dy++)
            for (int dx = 0; dx < 8; dx++) begin
                scanX.push_back(x0 + dx);
                scanY.push_back(y0 + dy);
            end
    endfunction

    // One random pixel per cell plus a few points beyond the active area.
    function automatic void add_full_scan();
        for (int cy = 0; cy < 60; cy++)
            for (int cx = 0; cx < 80; cx++) begin
                scanX.push_back(cx * 8 + int'($urandom_range(0, 7)));
                scanY.push_back(cy * 8 + int'($urandom_range(0, 7)));
            end
        for (int i = 0; i < 16; i++) begin
            scanX.push_back(int'($urandom_range(640, 1023)));
            scanY.push_back(int'($urandom_range(0, 1023)));
            scanX.push_back(int'($urandom_range(0, 639)));
            scanY.push_back(int'($urandom_range(480, 1023)));
        end
    endfunction

    // Streams the queued pixels one per cycle and collects colours three
    // cycles later; reports the number of disagreements and the first one.
    task automatic applyStimulus(output int bad, output int firstX, output int firstY,
                                 output logic [23:0] firstGot, output logic [23:0] firstExp);
        int n;
        logic [23:0] got;
        logic [23:0] exp;
        n = scanX.size();
        bad = 0;
        firstX = -1;
        firstY = -1;
        firstGot = '0;
        firstExp = '0;
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                pix_x = 10'(scanX[i]);
                pix_y = 10'(scanY[i]);
            end
            tick();
            if (i >= 2) begin
                got = {pix_r, pix_g, pix_b};
                exp = model_colour(scanX[i-2], scanY[i-2]);
                if (got !== exp) begin
                    if (bad == 0) begin
                        firstX = scanX[i-2];
                        firstY = scanY[i-2];
                        firstGot = got;
                        firstExp = exp;
                    end
                    bad++;
                end
            end
        end
        scanX.delete();
        scanY.delete();
    endtask

    // Issues one move and reports cycles from the accept cycle to move_done
    // (negative on timeout), the flags seen with it, and cycles spent
    // waiting for move_ready.
    task automatic do_move(input int player, input int x, input int y, output int lat,
                           output logic col, output logic cp, output int waited);
        waited = 0;
        while (move_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        lat = -2;
        col = 1'bx;
        cp = 1'bx;
        if (move_ready === 1'b1) begin
            move_valid = 1'b1;
            move_player = player[0];
            move_x = 10'(x);
            move_y = 10'(y);
            tick();
            move_valid = 1'b0;
            move_x = 10'($urandom);
            move_y = 10'($urandom);
            move_player = ~move_player;
            lat = -1;
            for (int i = 1; i <= 10; i++) begin
                tick();
                if (move_done === 1'b1) begin
                    lat = i + 1;
                    break;
                end
            end
            col = collision;
            cp = collision_player;
        end
    endtask

    task automatic test_reset();
        int cnt;
        int bad, fx, fy;
        logic [23:0] fg, fe;
        reset = 1'b1;
        repeat (3) tick();
        testsRun++;
        if ({busy, move_ready, move_done, collision, collision_player} !== 5'b10000) begin
            testsFailed++;
            $display("[TB] FAIL reset_flags: got busy/ready/done/col/cp=%b required 10000",
                     {busy, move_ready, move_done, collision, collision_player});
        end
        testsRun++;
        if ({pix_r, pix_g, pix_b} !== 24'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_rgb: got %h required 000000", {pix_r, pix_g, pix_b});
        end
        reset = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 6000) begin
            cnt++;
            tick();
        end
        testsRun++;
        if (cnt !== 4800) begin
            testsFailed++;
            $display("[TB] FAIL reset_clear_length: got %0d busy cycles required 4800", cnt);
        end
        testsRun++;
        if (move_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL ready_after_clear: got %b required 1", move_ready);
        end
        model_clear();
        add_full_scan();
        applyStimulus(bad, fx, fy, fg, fe);
        testsRun++;
        if (bad !== 0) begin
            testsFailed++;
            $display("[TB] FAIL empty_scan: %0d bad pixels, first (%0d,%0d) got %h required %h",
                     bad, fx, fy, fg, fe);
        end
    endtask

    task automatic test_p1_move();
        int lat, waited, bad, fx, fy;
        logic col, cp, expCol;
        logic [23:0] fg, fe;
        expCol = model_move(0, 219, 239);
        do_move(0, 219, 239, lat, col, cp, waited);
        testsRun++;
        if (lat !== 3 || col !== expCol) begin
            testsFailed++;
            $display("[TB] FAIL p1_move: got latency %0d col %b required latency 3 col %b",
                     lat, col, expCol);
        end
        add_cell_block(216, 232);
        applyStimulus(bad, fx, fy, fg, fe);
        testsRun++;
        if (bad !== 0) begin
            testsFailed++;
            $display("[TB] FAIL p1_cell_colour: %0d bad, first (%0d,%0d) got %h required %h",
                     bad, fx, fy, fg, fe);
        end
        scanX.push_back(224);
        scanY.push_back(239);
        scanX.push_back(215);
        scanY.push_back(231);
        applyStimulus(bad, fx, fy, fg, fe);
        testsRun++;
        if (bad !== 0) begin
            testsFailed++;
            $display("[TB] FAIL p1_neighbour: (%0d,%0d) got %h required %h", fx, fy, fg, fe);
        end
    endtask

    task automatic test_p2_same_cell();
        int lat, waited, bad, fx, fy;
        logic col, cp, expCol;
        logic [23:0] fg, fe;
        expCol = model_move(1, 219, 239);
        do_move(1, 219, 239, lat, col, cp, waited);
        testsRun++;
        if (lat !== 3 || col !== expCol || cp !== lastCrashPlayer[0]) begin
            testsFailed++;
            $display("[TB] FAIL p2_same_cell: got lat %0d col %b cp %b required 3 %b %0d",
                     lat, col, cp, expCol, lastCrashPlayer);
        end
        add_cell_block(216, 232);
        applyStimulus(bad, fx, fy, fg, fe);
        testsRun++;
        if (bad !== 0) begin
            testsFailed++;
            $display("[TB] FAIL cell_stays_p1: %0d bad, first (%0d,%0d) got %h required %h",
                     bad, fx, fy, fg, fe);
        end
    endtask

    task automatic test_offscreen_and_corner();
        int lat, waited, bad, fx, fy;
        logic col, cp, expCol;
        logic [23:0] fg, fe;
        expCol = model_move(0, 640, 0);
        do_move(0, 640, 0, lat, col, cp, waited);
        testsRun++;
        if (lat !== 3 || col !== expCol || cp !== lastCrashPlayer[0]) begin
            testsFailed++;
            $display("[TB] FAIL offscreen_x: got lat %0d col %b cp %b required 3 %b %0d",
                     lat, col, cp, expCol, lastCrashPlayer);
        end
        add_cell_block(0, 8);
        add_cell_block(0, 0);
        applyStimulus(bad, fx, fy, fg, fe);
        testsRun++;
        if (bad !== 0) begin
            testsFailed++;
            $display("[TB] FAIL offscreen_no_write: (%0d,%0d) got %h required %h", fx, fy, fg, fe);
        end
        expCol = model_move(1, 632, 472);
        do_move(1, 632, 472, lat, col, cp, waited);
        testsRun++;
        if (lat !== 3 || col !== expCol || cp !== lastCrashPlayer[0]) begin
            testsFailed++;
            $display("[TB] FAIL corner_move: got lat %0d col %b cp %b required 3 %b %0d",
                     lat, col, cp, expCol, lastCrashPlayer);
        end
        add_cell_block(632, 472);
        scanX.push_back(640);
        scanY.push_back(479);
        scanX.push_back(639);
        scanY.push_back(480);
        applyStimulus(bad, fx, fy, fg, fe);
        testsRun++;
        if (bad !== 0) begin
            testsFailed++;
            $display("[TB] FAIL corner_colour: (%0d,%0d) got %h required %h", fx, fy, fg, fe);
        end
    endtask

    task automatic test_back_to_back();
        int lat, waited, x, y, bad, fx, fy;
        logic col, cp, expCol;
        logic [23:0] fg, fe;
        x = 100;
        y = 100;
        while (grid[cell_index(x, y)] != 0) x += 8;
        expCol = model_move(0, x, y);
        do_move(0, x, y, lat, col, cp, waited);
        testsRun++;
        if (lat !== 3 || col !== expCol) begin
            testsFailed++;
            $display("[TB] FAIL b2b_first: got lat %0d col %b required 3 %b", lat, col, expCol);
        end
        expCol = model_move(1, x + 3, y + 5);
        do_move(1, x + 3, y + 5, lat, col, cp, waited);
        testsRun++;
        if (waited !== 0 || lat !== 3 || col !== expCol || cp !== lastCrashPlayer[0]) begin
            testsFailed++;
            $display("[TB] FAIL b2b_second: got wait %0d lat %0d col %b cp %b required 0 3 %b %0d",
                     waited, lat, col, cp, expCol, lastCrashPlayer);
        end
        add_cell_block(x - (x % 8), y - (y % 8));
        applyStimulus(bad, fx, fy, fg, fe);
        testsRun++;
        if (bad !== 0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_colour: (%0d,%0d) got %h required %h", fx, fy, fg, fe);
        end
    endtask

    task automatic test_random_moves();
        int lat, waited, x, y, p, sel, bad, fx, fy;
        int usedX [$];
        int usedY [$];
        logic col, cp, expCol;
        logic [23:0] fg, fe;
        for (int i = 0; i < 80; i++) begin
            p = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 2) begin
                x = int'($urandom_range(0, 1023));
                y = int'($urandom_range(480, 1023));
                if (sel == 1) begin
                    x = int'($urandom_range(640, 1023));
                    y = int'($urandom_range(0, 1023));
                end
            end else if (sel < 5 && usedX.size() > 0) begin
                int k;
                k = int'($urandom_range(0, usedX.size() - 1));
                x = usedX[k];
                y = usedY[k];
            end else begin
                x = int'($urandom_range(0, 639));
                y = int'($urandom_range(0, 479));
                usedX.push_back(x);
                usedY.push_back(y);
            end
            expCol = model_move(p, x, y);
            do_move(p, x, y, lat, col, cp, waited);
            testsRun++;
            if (lat !== 3 || col !== expCol || cp !== lastCrashPlayer[0]) begin
                testsFailed++;
                $display("[TB] FAIL random_move %0d (p%0d,%0d,%0d): got lat %0d col %b cp %b required 3 %b %0d",
                         i, p, x, y, lat, col, cp, expCol, lastCrashPlayer);
            end
        end
        add_full_scan();
        applyStimulus(bad, fx, fy, fg, fe);
        testsRun++;
        if (bad !== 0) begin
            testsFailed++;
            $display("[TB] FAIL random_scan: %0d bad, first (%0d,%0d) got %h required %h",
                     bad, fx, fy, fg, fe);
        end
    endtask

    task automatic test_clear_restart();
        int cnt, doneSeen, bad, fx, fy;
        logic readyAfter;
        logic [23:0] fg, fe;
        while (move_ready !== 1'b1 && cnt < 50) begin
            tick();
            cnt++;
        end
        move_valid = 1'b1;
        move_player = 1'b0;
        move_x = 10'd300;
        move_y = 10'd300;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        move_valid = 1'b0;
        readyAfter = move_ready;
        cnt = 0;
        doneSeen = 0;
        while (busy === 1'b1 && cnt < 12000) begin
            cnt++;
            if (move_done === 1'b1) doneSeen++;
            if (cnt == 100) clear_req = 1'b1;
            tick();
            clear_req = 1'b0;
        end
        testsRun++;
        if (cnt !== 4900) begin
            testsFailed++;
            $display("[TB] FAIL restart_clear_length: got %0d busy cycles required 4900", cnt);
        end
        testsRun++;
        if (doneSeen !== 0 || readyAfter !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL clear_beats_move: got done %0d ready %b required 0 0",
                     doneSeen, readyAfter);
        end
        model_clear();
        add_full_scan();
        applyStimulus(bad, fx, fy, fg, fe);
        testsRun++;
        if (bad !== 0) begin
            testsFailed++;
            $display("[TB] FAIL cleared_scan: %0d bad, first (%0d,%0d) got %h required %h",
                     bad, fx, fy, fg, fe);
        end
    endtask

    task automatic test_clear_during_check();
        int cnt, doneSeen, lat, waited, bad, fx, fy;
        logic col, cp, expCol, doneAtClear;
        logic [23:0] fg, fe;
        cnt = 0;
        while (move_ready !== 1'b1 && cnt < 50) begin
            tick();
            cnt++;
        end
        move_valid = 1'b1;
        move_player = 1'b1;
        move_x = 10'd300;
        move_y = 10'd200;
        tick();
        move_valid = 1'b0;
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        doneAtClear = move_done;
        cnt = 0;
        doneSeen = 0;
        while (busy === 1'b1 && cnt < 6000) begin
            cnt++;
            if (move_done === 1'b1) doneSeen++;
            tick();
        end
        testsRun++;
        if (doneAtClear !== 1'b0 || doneSeen !== 0 || cnt !== 4800) begin
            testsFailed++;
            $display("[TB] FAIL abandon_move: got done %b/%0d busy %0d required 0/0 4800",
                     doneAtClear, doneSeen, cnt);
        end
        model_clear();
        add_cell_block(296, 200);
        applyStimulus(bad, fx, fy, fg, fe);
        testsRun++;
        if (bad !== 0) begin
            testsFailed++;
            $display("[TB] FAIL abandoned_cell: (%0d,%0d) got %h required %h", fx, fy, fg, fe);
        end
        expCol = model_move(0, 300, 200);
        do_move(0, 300, 200, lat, col, cp, waited);
        testsRun++;
        if (lat !== 3 || col !== expCol) begin
            testsFailed++;
            $display("[TB] FAIL move_after_abandon: got lat %0d col %b required 3 %b",
                     lat, col, expCol);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_p1_move();
        test_p2_same_cell();
        test_offscreen_and_corner();
        test_back_to_back();
        test_random_moves();
        test_clear_restart();
        test_clear_during_check();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
